// File: rtl/player_pkg.sv
// ----------------------------------------------------------------------------
// player_pkg
// Shared definitions for the player sprite fetch stage: facing direction
// encoding, sprite geometry, animation constants, ROM sizing and the helper
// that maps the latched animation state onto a ROM slot number.
// ----------------------------------------------------------------------------
package player_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    localparam int SPR_W           = 32;
    localparam int SPR_H           = 64;
    localparam int NUM_WALK        = 4;
    localparam int FRAMES_PER_STEP = 6;
    localparam logic [8:0] TRANSPARENT_IDX = 9'd0;

    localparam int SLOT_WORDS = SPR_W * SPR_H;
    localparam int NUM_SLOTS  = 1 + 2 * NUM_WALK;
    localparam int ROM_AW     = 15;
    localparam int ROM_DEPTH  = NUM_SLOTS * SLOT_WORDS;

    localparam int SPR_XB    = $clog2(SPR_W);
    localparam int SPR_YB    = $clog2(SPR_H);
    localparam int WALK_BITS = $clog2(NUM_WALK);
    localparam int STEP_BITS = $clog2(FRAMES_PER_STEP);
    localparam int SLOT_BITS = 4;

    // Slot 0 is the forward pose, slots 1..NUM_WALK the left walk cycle and
    // the next NUM_WALK slots the right walk cycle. Direction code 3 and a
    // standing player both fall back to the forward pose.
    function automatic logic [SLOT_BITS-1:0] slot_of(
        input logic [1:0]           d,
        input logic                 mv,
        input logic [WALK_BITS-1:0] wf
    );
        logic [SLOT_BITS-1:0] s;
        s = '0;
        if (mv) begin
            if (d == DIR_LEFT) begin
                s = SLOT_BITS'(1 + int'(wf));
            end else if (d == DIR_RIGHT) begin
                s = SLOT_BITS'(1 + NUM_WALK + int'(wf));
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/player_sprite_rom.sv
// ----------------------------------------------------------------------------
// player_sprite_rom
// Sprite image store: NUM_SLOTS animation frames of SPR_W x SPR_H palette
// indices, one 9-bit word per pixel. Synchronous read, one word per clock.
// The array is the target of the sprite hex image during memory
// initialisation at build time; the design only ever reads it.
//
// Ports:
//   Clk   in   pixel clock
//   addr  in   ROM_AW-bit word address (slot*SLOT_WORDS + row*SPR_W + col)
//   q     out  9-bit palette index, registered (one cycle after addr)
// ----------------------------------------------------------------------------
module player_sprite_rom
    import player_pkg::*;
(
    input  logic              Clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [8:0]        q
);

    logic [8:0] mem [0:ROM_DEPTH-1];

    // No reset on the read register so the array maps onto block RAM.
    always_ff @(posedge Clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/player_sprite_fetch.sv
// ----------------------------------------------------------------------------
// player_sprite_fetch
// Per-pixel fetch of the player sprite. Decides whether the player covers
// the current VGA pixel, picks the animation slot (forward or a left/right
// walk frame) and reads the palette index from the sprite ROM. Outputs
// follow DrawX/DrawY by two clocks at one pixel per clock, no stalls.
//
// Ports:
//   Clk           in   pixel clock
//   Reset         in   synchronous, active-high reset
//   frame_start   in   one-cycle pulse at the start of vertical blank
//   DrawX/DrawY   in   current pixel column/row (10 bits)
//   PlayerX/Y     in   sprite top-left corner (10 bits)
//   dir           in   0 forward, 1 left, 2 right, 3 treated as forward
//   moving        in   player walking
//   sprite_index  out  9-bit palette index
//   sprite_on     out  sprite pixel present and not transparent
//   anim_slot     out  latched ROM slot (debug view of the animation state)
// ----------------------------------------------------------------------------
module player_sprite_fetch
    import player_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           PlayerX,
    input  logic [9:0]           PlayerY,
    input  logic [1:0]           dir,
    input  logic                 moving,
    output logic [8:0]           sprite_index,
    output logic                 sprite_on,
    output logic [SLOT_BITS-1:0] anim_slot
);

    // ------------------------------------------------------------------
    // Animation state: only touched on frame_start so the slot is
    // constant for a whole frame.
    // ------------------------------------------------------------------
    logic [1:0]           dir_q;
    logic                 moving_q;
    logic [STEP_BITS-1:0] step_cnt;
    logic [WALK_BITS-1:0] walk_frame;
    logic [SLOT_BITS-1:0] slot_q;

    logic [STEP_BITS-1:0] step_nxt;
    logic [WALK_BITS-1:0] walk_nxt;
    logic                 restart;

    // A direction change, a stop or a forward pose restarts the walk cycle.
    assign restart = (dir != dir_q) || !moving ||
                     (dir == DIR_FWD) || (dir == 2'd3);

    always_comb begin
        step_nxt = step_cnt;
        walk_nxt = walk_frame;
        if (restart) begin
            step_nxt = '0;
            walk_nxt = '0;
        end else if (step_cnt == STEP_BITS'(FRAMES_PER_STEP - 1)) begin
            step_nxt = '0;
            walk_nxt = (walk_frame == WALK_BITS'(NUM_WALK - 1)) ?
                       '0 : walk_frame + 1'b1;
        end else begin
            step_nxt = step_cnt + 1'b1;
        end
    end

    // The slot is registered from the next-state values so it is already
    // correct right after the frame_start edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_q      <= '0;
            moving_q   <= 1'b0;
            step_cnt   <= '0;
            walk_frame <= '0;
            slot_q     <= '0;
        end else if (frame_start) begin
            dir_q      <= dir;
            moving_q   <= moving;
            step_cnt   <= step_nxt;
            walk_frame <= walk_nxt;
            slot_q     <= slot_of(dir, moving, walk_nxt);
        end
    end

    assign anim_slot = slot_q;

    // ------------------------------------------------------------------
    // Stage 0: hit test and ROM address. 11-bit arithmetic keeps a sprite
    // hanging off the right/bottom edge from wrapping back into view.
    // ------------------------------------------------------------------
    logic [10:0]       rel_x;
    logic [10:0]       rel_y;
    logic              hit;
    logic [ROM_AW-1:0] addr_d;

    assign rel_x = {1'b0, DrawX} - {1'b0, PlayerX};
    assign rel_y = {1'b0, DrawY} - {1'b0, PlayerY};

    assign hit = (DrawX >= PlayerX) && (rel_x < 11'(SPR_W)) &&
                 (DrawY >= PlayerY) && (rel_y < 11'(SPR_H));

    // Power-of-two sprite dimensions make the address a plain concatenation.
    assign addr_d = hit ? {slot_q, rel_y[SPR_YB-1:0], rel_x[SPR_XB-1:0]}
                        : '0;

    // ------------------------------------------------------------------
    // Stage 1 registers, stage 2 ROM read.
    // ------------------------------------------------------------------
    logic [ROM_AW-1:0] addr_q;
    logic              hit_q;
    logic              hit_qq;
    logic              blank_q;
    logic [8:0]        rom_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q <= '0;
            hit_q  <= 1'b0;
            hit_qq <= 1'b0;
        end else begin
            addr_q <= addr_d;
            hit_q  <= hit;
            hit_qq <= hit_q;
        end
        blank_q <= Reset;
    end

    player_sprite_rom u_rom (
        .Clk  (Clk),
        .addr (addr_q),
        .q    (rom_q)
    );

    // The ROM read register carries no reset, so it is masked for the
    // cycle that follows a reset edge to present a cleared index.
    assign sprite_index = blank_q ? 9'd0 : rom_q;
    assign sprite_on    = hit_qq && (sprite_index != TRANSPARENT_IDX);

endmodule

// File: tb/tb_player_sprite_fetch.sv
// ----------------------------------------------------------------------------
// tb_player_sprite_fetch
// Directed bench for player_sprite_fetch. The ROM image is a known pattern
// written straight into the array, so every expected palette index follows
// from the sprite geometry alone. A DrawX driven just after edge N appears
// on the outputs after edge N+2.
// ----------------------------------------------------------------------------
module tb_player_sprite_fetch;
    import player_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] PlayerX = '0;
    logic [9:0] PlayerY = '0;
    logic [1:0] dir = '0;
    logic       moving = 1'b0;
    logic [8:0] sprite_index;
    logic       sprite_on;
    logic [3:0] anim_slot;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    player_sprite_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .dir          (dir),
        .moving       (moving),
        .sprite_index (sprite_index),
        .sprite_on    (sprite_on),
        .anim_slot    (anim_slot)
    );

    // ROM pattern: low address bits xor'ed with the upper bits shifted up,
    // so the word depends on the slot as well as the pixel offset.
    function automatic logic [8:0] rom_word(input int a);
        return 9'((a & 511) ^ (((a >> 9) & 63) << 3));
    endfunction

    function automatic logic [8:0] exp_index(input int slot, input int dx,
                                             input int dy, input int px,
                                             input int py);
        int rx;
        int ry;
        rx = dx - px;
        ry = dy - py;
        if (rx < 0 || rx >= 32 || ry < 0 || ry >= 64) return rom_word(0);
        return rom_word(slot * 2048 + ry * 32 + rx);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (sprite_index !== 9'd0) begin
            errors++;
            $display("FAIL reset_index: got %0d expected 0", sprite_index);
        end
        checks++;
        if (sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_on: got %0b expected 0", sprite_on);
        end
        checks++;
        if (anim_slot !== 4'd0) begin
            errors++;
            $display("FAIL reset_slot: got %0d expected 0", anim_slot);
        end
        Reset = 1'b0;
        tick();
    endtask

    // Back-to-back sweep across the sprite's left and right edges.
    task automatic test_hit_window();
        int x;
        logic [8:0] ei;
        logic eo;
        PlayerX = 10'd100; PlayerY = 10'd200; dir = 2'd0; moving = 1'b0;
        DrawY = 10'd210;
        for (int k = 0; k <= 41; k++) begin
            if (k < 41) DrawX = 10'(95 + k);
            tick();
            if (k >= 1) begin
                x  = 95 + k - 1;
                ei = exp_index(0, x, 210, 100, 200);
                eo = (x >= 100 && x <= 131) && (ei != 9'd0);
                checks++;
                if (sprite_index !== ei || sprite_on !== eo) begin
                    errors++;
                    $display("FAIL hit_window x=%0d: got idx=%0d on=%0b expected idx=%0d on=%0b",
                             x, sprite_index, sprite_on, ei, eo);
                end
            end
        end
        // Top-left pixel reads word 0: covered but transparent.
        DrawX = 10'd100; DrawY = 10'd200;
        tick(); tick();
        checks++;
        if (sprite_index !== 9'd0 || sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL transparent: got idx=%0d on=%0b expected idx=0 on=0",
                     sprite_index, sprite_on);
        end
        // Bottom-right pixel of the sprite: addr 2047 -> 511 ^ 24 = 487.
        DrawX = 10'd131; DrawY = 10'd263;
        tick(); tick();
        checks++;
        if (sprite_index !== 9'd487 || sprite_on !== 1'b1) begin
            errors++;
            $display("FAIL bottom_right: got idx=%0d on=%0b expected idx=487 on=1",
                     sprite_index, sprite_on);
        end
        // One row below the sprite.
        DrawY = 10'd264;
        tick(); tick();
        checks++;
        if (sprite_index !== 9'd0 || sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL below_sprite: got idx=%0d on=%0b expected idx=0 on=0",
                     sprite_index, sprite_on);
        end
    endtask

    task automatic test_address_map();
        DrawX = 10'd105; DrawY = 10'd203;
        tick(); tick();
        checks++;
        if (sprite_index !== 9'd101 || sprite_on !== 1'b1) begin
            errors++;
            $display("FAIL address_map: got idx=%0d on=%0b expected idx=101 on=1",
                     sprite_index, sprite_on);
        end
    endtask

    task automatic test_walk();
        int es;
        logic [8:0] ei;
        PlayerX = 10'd100; PlayerY = 10'd200; DrawX = 10'd110; DrawY = 10'd230;
        dir = 2'd2; moving = 1'b1;
        for (int p = 1; p <= 30; p++) begin
            pulse();
            es = 5 + ((p - 1) / 6) % 4;
            checks++;
            if (anim_slot !== 4'(es)) begin
                errors++;
                $display("FAIL walk_slot pulse=%0d: got %0d expected %0d", p, anim_slot, es);
            end
            tick(); tick();
            ei = exp_index(es, 110, 230, 100, 200);
            checks++;
            if (sprite_index !== ei) begin
                errors++;
                $display("FAIL walk_index pulse=%0d: got %0d expected %0d", p, sprite_index, ei);
            end
        end
        dir = 2'd1;
        pulse();
        checks++;
        if (anim_slot !== 4'd1) begin
            errors++;
            $display("FAIL walk_turn_left: got %0d expected 1", anim_slot);
        end
    endtask

    task automatic test_mid_frame();
        logic [8:0] ei;
        ei = exp_index(1, 110, 230, 100, 200);
        for (int t = 0; t < 2; t++) begin
            dir = (t == 0) ? 2'd2 : 2'd0;
            tick(); tick(); tick();
            checks++;
            if (anim_slot !== 4'd1 || sprite_index !== ei) begin
                errors++;
                $display("FAIL mid_frame dir=%0d: got slot=%0d idx=%0d expected slot=1 idx=%0d",
                         dir, anim_slot, sprite_index, ei);
            end
        end
        dir = 2'd1;
        for (int p = 1; p <= 3; p++) begin
            pulse();
            checks++;
            if (anim_slot !== 4'd1) begin
                errors++;
                $display("FAIL step_left pulse=%0d: got %0d expected 1", p, anim_slot);
            end
        end
        moving = 1'b0;
        pulse();
        checks++;
        if (anim_slot !== 4'd0) begin
            errors++;
            $display("FAIL stop_slot: got %0d expected 0", anim_slot);
        end
        tick(); tick();
        ei = exp_index(0, 110, 230, 100, 200);
        checks++;
        if (sprite_index !== ei) begin
            errors++;
            $display("FAIL stop_index: got %0d expected %0d", sprite_index, ei);
        end
        // Counters were cleared: five pulses stay on frame 0, the sixth advances.
        moving = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            pulse();
            checks++;
            if (anim_slot !== ((p == 6) ? 4'd2 : 4'd1)) begin
                errors++;
                $display("FAIL restart_count pulse=%0d: got %0d expected %0d",
                         p, anim_slot, (p == 6) ? 2 : 1);
            end
        end
    endtask

    task automatic test_edge_wrap();
        int x;
        int vx[4] = '{0, 5, 20, 639};
        logic [8:0] ei;
        logic eo;
        dir = 2'd0; moving = 1'b0;
        pulse();
        checks++;
        if (anim_slot !== 4'd0) begin
            errors++;
            $display("FAIL edge_slot: got %0d expected 0", anim_slot);
        end
        PlayerX = 10'd620; PlayerY = 10'd200; DrawY = 10'd210;
        for (int k = 0; k <= 25; k++) begin
            x = (k < 25) ? 615 + k : 0;
            DrawX = 10'(x);
            tick(); tick();
            ei = exp_index(0, x, 210, 620, 200);
            eo = (x >= 620 && x <= 639);
            checks++;
            if (sprite_index !== ei || sprite_on !== eo) begin
                errors++;
                $display("FAIL edge_right x=%0d: got idx=%0d on=%0b expected idx=%0d on=%0b",
                         x, sprite_index, sprite_on, ei, eo);
            end
        end
        PlayerX = 10'd1000;
        for (int k = 0; k < 4; k++) begin
            DrawX = 10'(vx[k]);
            tick(); tick();
            checks++;
            if (sprite_index !== 9'd0 || sprite_on !== 1'b0) begin
                errors++;
                $display("FAIL offscreen x=%0d: got idx=%0d on=%0b expected idx=0 on=0",
                         vx[k], sprite_index, sprite_on);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] ei;
        PlayerX = 10'd100; PlayerY = 10'd200; DrawX = 10'd110; DrawY = 10'd210;
        dir = 2'd2; moving = 1'b1;
        pulse();
        tick(); tick();
        ei = exp_index(5, 110, 210, 100, 200);
        checks++;
        if (anim_slot !== 4'd5 || sprite_on !== 1'b1 || sprite_index !== ei) begin
            errors++;
            $display("FAIL pre_reset: got slot=%0d on=%0b idx=%0d expected slot=5 on=1 idx=%0d",
                     anim_slot, sprite_on, sprite_index, ei);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (sprite_on !== 1'b0 || sprite_index !== 9'd0 || anim_slot !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got on=%0b idx=%0d slot=%0d expected on=0 idx=0 slot=0",
                     sprite_on, sprite_index, anim_slot);
        end
        tick();
        checks++;
        if (sprite_on !== 1'b0) begin
            errors++;
            $display("FAIL release_plus1: got on=%0b expected 0", sprite_on);
        end
        tick();
        ei = exp_index(0, 110, 210, 100, 200);
        checks++;
        if (sprite_on !== 1'b1 || sprite_index !== ei) begin
            errors++;
            $display("FAIL release_plus2: got on=%0b idx=%0d expected on=1 idx=%0d",
                     sprite_on, sprite_index, ei);
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) begin
            dut.u_rom.mem[i] = rom_word(i);
        end
        test_reset();
        test_hit_window();
        test_address_map();
        test_walk();
        test_mid_frame();
        test_edge_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
